// File: rtl/imem_loader.sv
// imem_loader: fills instruction memory from a little-endian byte stream.
// Ports: clk/rst, start+base_addr+word_count, s_valid/s_data/s_ready, mem_we/addr/wdata, busy/done/error/checksum.
module imem_loader #(
    parameter int MEM_DEPTH         = 1024,
    parameter int INSTRUCTION_WIDTH = 32,
    parameter int CNT_WIDTH         = 11
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [31:0]                  base_addr,
    input  logic [CNT_WIDTH-1:0]         word_count,
    input  logic                         s_valid,
    input  logic [7:0]                   s_data,
    output logic                         s_ready,
    output logic                         mem_we,
    output logic [31:0]                  mem_addr,
    output logic [INSTRUCTION_WIDTH-1:0] mem_wdata,
    output logic                         busy,
    output logic                         done,
    output logic                         error,
    output logic [31:0]                  checksum
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DONE
    } state_t;

    state_t                 state_q;
    logic [31:0]            base_q;
    logic [CNT_WIDTH-1:0]   count_q;
    logic [CNT_WIDTH-1:0]   word_idx_q;
    logic [1:0]             byte_idx_q;
    logic [23:0]            buf_q;
    logic                   mem_we_q;
    logic [31:0]            mem_addr_q;
    logic [31:0]            mem_wdata_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   error_q;
    logic [31:0]            checksum_q;

    logic [31:0]            word_d;
    logic [32:0]            end_d;
    logic                   range_err_d;
    logic [CNT_WIDTH-1:0]   word_idx_d;
    logic                   last_word_d;
    logic [31:0]            addr_d;

    // Byte 3 completes the word directly from the input bus.
    assign word_d      = {s_data, buf_q};
    // 33-bit sum so a huge base_addr cannot wrap past the depth check.
    assign end_d       = {1'b0, base_addr} + 33'(word_count);
    assign range_err_d = end_d > 33'(MEM_DEPTH);
    assign word_idx_d  = word_idx_q + CNT_WIDTH'(1);
    assign last_word_d = (word_idx_d == count_q);
    assign addr_d      = base_q + 32'(word_idx_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            base_q      <= '0;
            count_q     <= '0;
            word_idx_q  <= '0;
            byte_idx_q  <= '0;
            buf_q       <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            checksum_q  <= '0;
        end else begin
            mem_we_q <= 1'b0;
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        base_q     <= base_addr;
                        count_q    <= word_count;
                        word_idx_q <= '0;
                        byte_idx_q <= '0;
                        buf_q      <= '0;
                        checksum_q <= '0;
                        error_q    <= 1'b0;
                        done_q     <= 1'b0;
                        if (word_count == '0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else if (range_err_d) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                            error_q <= 1'b1;
                        end else begin
                            state_q <= S_LOAD;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    if (s_valid) begin
                        if (byte_idx_q == 2'd3) begin
                            mem_we_q    <= 1'b1;
                            mem_addr_q  <= addr_d;
                            mem_wdata_q <= word_d;
                            checksum_q  <= checksum_q + word_d;
                            word_idx_q  <= word_idx_d;
                            byte_idx_q  <= '0;
                            if (last_word_d) begin
                                state_q <= S_DONE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end
                        end else begin
                            buf_q[8*byte_idx_q +: 8] <= s_data;
                            byte_idx_q <= byte_idx_q + 2'd1;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign s_ready   = (state_q == S_LOAD);
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;
    assign checksum  = checksum_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed stimulus with a write scoreboard for imem_loader.
// Expected writes are queued at stimulus time and popped by a negedge monitor.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] base_addr;
    logic [10:0] word_count;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        error;
    logic [31:0] checksum;

    always #5 clk = ~clk;

    imem_loader #(
        .MEM_DEPTH(1024),
        .INSTRUCTION_WIDTH(32),
        .CNT_WIDTH(11)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .base_addr(base_addr),
        .word_count(word_count),
        .s_valid(s_valid),
        .s_data(s_data),
        .s_ready(s_ready),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .busy(busy),
        .done(done),
        .error(error),
        .checksum(checksum)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    wr_t e;
    int  wr_cyc[$];
    int  cyc = 0;
    int  checks = 0;
    int  errors = 0;
    int  wr_total = 0;
    int  ready_viol = 0;
    int  ready_seen = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pops one expected write per mem_we pulse.
    always @(negedge clk) begin
        if (!rst && mem_we) begin
            wr_total = wr_total + 1;
            wr_cyc.push_back(cyc);
            checks = checks + 1;
            if (exp_q.size() == 0) begin
                errors = errors + 1;
                $display("FAIL unexpected_write: got addr=%h data=%h, expected none",
                         mem_addr, mem_wdata);
            end else begin
                e = exp_q.pop_front();
                if (mem_addr !== e.addr || mem_wdata !== e.data) begin
                    errors = errors + 1;
                    $display("FAIL write: got %h@%h expected %h@%h",
                             mem_wdata, mem_addr, e.data, e.addr);
                end
            end
        end
        if (busy && !s_ready) ready_viol = ready_viol + 1;
        if (s_ready) ready_seen = ready_seen + 1;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_wr(input logic [31:0] a, input logic [31:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        exp_q.push_back(w);
    endtask

    task automatic do_start(input logic [31:0] b, input logic [10:0] n);
        start      = 1'b1;
        base_addr  = b;
        word_count = n;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit thr);
        bit acc;
        bit ok;
        ok      = 1'b0;
        s_valid = 1'b1;
        s_data  = b;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            acc = s_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                ok = 1'b1;
                break;
            end
        end
        s_valid = 1'b0;
        if (!ok) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL byte_timeout: got no handshake expected s_ready within 50 cycles");
        end
        if (thr) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_word(input logic [31:0] w, input bit thr);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], thr);
    endtask

    int snap;

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        base_addr  = '0;
        word_count = '0;
        s_valid    = 1'b0;
        s_data     = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        @(negedge clk);
        chk("rst_s_ready", 32'(s_ready), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_checksum", checksum, 32'd0);

        // Reset mid-word discards the partial word.
        @(posedge clk);
        #1;
        do_start(32'd0, 11'd1);
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_s_ready", 32'(s_ready), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_mem_we", 32'(mem_we), 32'd0);
        @(posedge clk);
        #1;
        expect_wr(32'd0, 32'h44332211);
        do_start(32'd0, 11'd1);
        send_word(32'h44332211, 1'b0);
        @(negedge clk);
        chk("single_done", 32'(done), 32'd1);
        chk("single_busy", 32'(busy), 32'd0);
        chk("single_checksum", checksum, 32'h44332211);

        // Back-to-back stream.
        @(posedge clk);
        #1;
        wr_cyc.delete();
        expect_wr(32'd0, 32'hE3A00001);
        expect_wr(32'd1, 32'hE2800002);
        do_start(32'd0, 11'd2);
        send_word(32'hE3A00001, 1'b0);
        send_word(32'hE2800002, 1'b0);
        @(negedge clk);
        chk("basic_done", 32'(done), 32'd1);
        chk("basic_busy", 32'(busy), 32'd0);
        chk("basic_error", 32'(error), 32'd0);
        chk("basic_s_ready", 32'(s_ready), 32'd0);
        chk("basic_checksum", checksum, 32'hC6200003);
        @(posedge clk);
        #1;
        chk("basic_nwrites", 32'(wr_cyc.size()), 32'd2);
        if (wr_cyc.size() == 2)
            chk("basic_spacing", 32'(wr_cyc[1] - wr_cyc[0]), 32'd4);

        // Throttled stream.
        wr_cyc.delete();
        ready_viol = 0;
        expect_wr(32'd0, 32'hE3A00001);
        expect_wr(32'd1, 32'hE2800002);
        do_start(32'd0, 11'd2);
        send_word(32'hE3A00001, 1'b1);
        send_word(32'hE2800002, 1'b1);
        @(negedge clk);
        chk("thr_done", 32'(done), 32'd1);
        chk("thr_checksum", checksum, 32'hC6200003);
        chk("thr_ready_drop", 32'(ready_viol), 32'd0);
        chk("thr_nwrites", 32'(wr_cyc.size()), 32'd2);

        // Top-of-memory boundary: fits exactly.
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++)
            expect_wr(32'(1020 + i), 32'(i + 1));
        do_start(32'd1020, 11'd4);
        for (int i = 0; i < 4; i++)
            send_word(32'(i + 1), 1'b0);
        @(negedge clk);
        chk("bnd_done", 32'(done), 32'd1);
        chk("bnd_error", 32'(error), 32'd0);
        chk("bnd_checksum", checksum, 32'h0000000A);

        // One past the top: range error, no handshake.
        @(posedge clk);
        #1;
        snap       = wr_total;
        ready_seen = 0;
        do_start(32'd1021, 11'd4);
        s_valid = 1'b1;
        s_data  = 8'hFF;
        @(negedge clk);
        chk("oor_done", 32'(done), 32'd1);
        chk("oor_error", 32'(error), 32'd1);
        chk("oor_busy", 32'(busy), 32'd0);
        chk("oor_checksum", checksum, 32'd0);
        repeat (5) @(posedge clk);
        #1;
        s_valid = 1'b0;
        chk("oor_ready_seen", 32'(ready_seen), 32'd0);
        chk("oor_nwrites", 32'(wr_total - snap), 32'd0);

        // Zero-length load.
        snap = wr_total;
        do_start(32'd5, 11'd0);
        @(negedge clk);
        chk("zero_done", 32'(done), 32'd1);
        chk("zero_error", 32'(error), 32'd0);
        chk("zero_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        chk("zero_nwrites", 32'(wr_total - snap), 32'd0);

        // Start during a load is ignored.
        expect_wr(32'd10, 32'h00000100);
        expect_wr(32'd11, 32'h00000200);
        expect_wr(32'd12, 32'h00000300);
        do_start(32'd10, 11'd3);
        send_word(32'h00000100, 1'b0);
        send_byte(8'h00, 1'b0);
        do_start(32'd500, 11'd1);
        send_byte(8'h02, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        send_word(32'h00000300, 1'b0);
        @(negedge clk);
        chk("ign_done", 32'(done), 32'd1);
        chk("ign_busy", 32'(busy), 32'd0);
        chk("ign_checksum", checksum, 32'h00000600);

        repeat (3) @(posedge clk);
        #1;
        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        chk("total_writes", 32'(wr_total), 32'd12);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Program loader that fills the instruction memory before the core runs. It accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words. Each word is written to consecutive word addresses on the memory's write port. It reports busy/done/error and a running 32-bit checksum, so the fetch path only starts reading once the image is fully written.

Parameters:
MEM_DEPTH, 1024, number of 32-bit words in the instruction memory
INSTRUCTION_WIDTH, 32, instruction word width (fixed at 32; 4 bytes per word)
CNT_WIDTH, 11, width of word_count, i.e. $clog2(MEM_DEPTH)+1

Ports:
clk  in  1  single clock; all logic rising-edge
rst  in  1  reset; synchronous, active-high
start  in  1  one-cycle pulse; begins a load when not busy
base_addr  in  32  first word index to write; latched on accepted start
word_count  in  CNT_WIDTH  number of words to load; latched on accepted start
s_valid  in  1  input byte valid
s_data  in  8  input byte
s_ready  out  1  loader can accept a byte
mem_we  out  1  one-cycle write strobe to instruction memory
mem_addr  out  32  word index for the write
mem_wdata  out  32  assembled instruction word
busy  out  1  load in progress
done  out  1  load finished (success or error); sticky until next accepted start
error  out  1  range error on last start; sticky until next accepted start
checksum  out  32  sum mod 2^32 of all words written since last accepted start

Behaviour:
- Single clock, synchronous active-high reset, as stated in Ports.
- Reset values: s_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, error=0, checksum=0; byte index=0; word index=0; state=IDLE.
- States: IDLE, LOAD, DONE.
- IDLE/DONE, start=1 is accepted. On the next edge it latches base_addr/word_count and clears done, error and checksum. Then:
  - word_count==0 -> DONE; done=1, no writes.
  - base_addr+word_count > MEM_DEPTH (33-bit compare, no wrap) -> DONE; done=1, error=1, no writes.
  - otherwise -> LOAD; busy=1.
- LOAD: s_ready=1 combinationally (s_ready = state==LOAD). A byte transfers when s_valid && s_ready.
  - Byte k (k=0..3) of a word goes to bits [8k+7:8k]; byte 0 is the LSB.
  - On the edge accepting byte 3:
    - mem_we<=1, mem_addr<=base+word_idx, mem_wdata<=assembled word (byte 3 included).
    - checksum<=checksum+word.
    - word_idx increments; byte index returns to 0.
  - mem_we is high for exactly one cycle per word. Write latency is 1 cycle after the 4th byte handshake.
  - Back-to-back bytes are allowed at one per cycle, with no bubble between words.
  - mem_addr/mem_wdata hold their last values when mem_we=0.
- Last word: on the edge accepting byte 3 of word word_count-1, state->DONE. That same edge sets busy<=0 and done<=1, and s_ready drops. That word's mem_we pulse coincides with the first DONE cycle.
- start while busy is ignored. s_valid outside LOAD is ignored (no handshake).
- s_valid low mid-word holds the partial word indefinitely; there is no timeout.
- Reset mid-load: the partial word is discarded and all outputs/state return to reset values next cycle. Memory words already written are not undone.
- Arithmetic: mem_addr = base_addr + word_idx, 32-bit. The range check guarantees mem_addr < MEM_DEPTH for every write. checksum wraps mod 2^32.

Test Plan:
- Reset mid-word: assert rst after 2 bytes -> next cycle all outputs 0, state IDLE. New start base=0,count=1 with bytes 11 22 33 44 -> single write 0x44332211 at addr 0.
- Basic load: base=0, count=2, bytes 01 00 A0 E3 02 00 80 E2 streamed with s_valid high every cycle -> writes 0xE3A00001@0 then 0xE2800002@1. mem_we high exactly 2 cycles, 4 cycles apart. done=1, busy=0, checksum=0xC6200003, error=0.
- Throttled stream: same data with s_valid toggling 1/0 -> identical writes and checksum; s_ready stays 1 throughout LOAD; no extra mem_we.
- Boundary: base=1020, count=4 -> writes to 1020..1023, done=1, error=0. Then base=1021, count=4 -> no mem_we, done=1, error=1, s_ready never asserts.
- Zero/ignored start: count=0 -> done=1 next cycle, no writes. During a 3-word load, pulse start with base=500 -> ignored; writes remain at original base..base+2.
